// File: rtl/rf_dumper_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_dumper_if
// Purpose  : Command, register-file port and dump-stream bundle for rf_dumper.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_dumper_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          start;
   logic          clear;
   logic          busy;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_idx;
   logic [DW-1:0] out_data;
   logic          done;

   modport master (
      input  start, clear, rd_data, out_ready,
      output busy, rd_addr, wr_en, wr_addr, wr_data,
      output out_valid, out_idx, out_data, done
   );

   modport slave (
      output start, clear, rd_data, out_ready,
      input  busy, rd_addr, wr_en, wr_addr, wr_data,
      input  out_valid, out_idx, out_data, done
   );
endinterface
`default_nettype wire

// File: rtl/rf_dumper.sv
`default_nettype none
// ============================================================================
// Module   : rf_dumper
// Purpose  : Walks the register file to stream every value out or zero it.
// Revision : 1.0 - initial release
// ============================================================================
module rf_dumper #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  wire logic   clk,
   input  wire logic   rst,
   rf_dumper_if.master bus
);
   localparam logic [AW-1:0] c_LAST = AW'(NREGS - 1);
   localparam logic [AW-1:0] c_ONE  = AW'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DUMP_RD  = 3'd1,
      S_DUMP_OUT = 3'd2,
      S_CLEAR    = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_idx;
   logic          r_busy;
   logic          r_wr_en;
   logic          r_out_valid;
   logic [AW-1:0] r_out_idx;
   logic [DW-1:0] r_out_data;
   logic          r_done;

   // Outputs are set on the transition into each state so they behave as Moore outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_busy      <= 1'b0;
         r_wr_en     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_out_data  <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_idx  <= '0;
                  r_busy <= 1'b1;
                  if (bus.clear) begin
                     r_state <= S_CLEAR;
                     r_wr_en <= 1'b1;
                  end else begin
                     r_state <= S_DUMP_RD;
                  end
               end
            end
            S_DUMP_RD: begin
               r_out_data  <= bus.rd_data;
               r_out_idx   <= r_idx;
               r_out_valid <= 1'b1;
               r_state     <= S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_idx == c_LAST) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + c_ONE;
                     r_state <= S_DUMP_RD;
                  end
               end
            end
            S_CLEAR: begin
               // Terminal compare precedes the increment so the index never wraps.
               if (r_idx == c_LAST) begin
                  r_wr_en <= 1'b0;
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= r_idx + c_ONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_idx   <= '0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_idx       <= '0;
               r_busy      <= 1'b0;
               r_wr_en     <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.rd_addr   = r_idx;
   assign bus.wr_en     = r_wr_en;
   assign bus.wr_addr   = r_idx;
   assign bus.wr_data   = '0;
   assign bus.out_valid = r_out_valid;
   assign bus.out_idx   = r_out_idx;
   assign bus.out_data  = r_out_data;
   assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_rf_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_dumper
// Purpose  : Directed bench for rf_dumper with a behavioural 32x32 register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_dumper;
   logic        clk;
   logic        rst;
   logic        pl_req;
   logic        pl_mode;
   logic [31:0] regs [32];
   int          n_pass;
   int          n_tot;

   rf_dumper_if #(.AW(5), .DW(32)) bus ();

   rf_dumper #(.NREGS(32), .AW(5), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file: bulk preload port for the bench, write port driven by the DUT.
   assign bus.rd_data = regs[bus.rd_addr];
   always @(posedge clk) begin
      if (pl_req) begin
         for (int k = 0; k < 32; k++)
            regs[k] <= pl_mode ? 32'hFFFF_FFFF : (32'hA5A5_0000 + 32'(k));
      end else if (bus.wr_en) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic preload(input logic mode);
      pl_mode = mode;
      pl_req  = 1'b1;
      tick();
      pl_req  = 1'b0;
   endtask

   // Dump with optional stall of L cycles starting at cycle s and optional ignored start pulses.
   task automatic run_dump(input int s, input int L, input bit zeros, input bit pulses);
      int  cp;
      int  recs;
      int  dones;
      int  idx;
      bit  ev;
      recs = 0;
      dones = 0;
      bus.start = 1'b1;
      bus.clear = 1'b0;
      bus.out_ready = 1'b1;
      chk("dump_c0_busy", 64'(bus.busy), 64'd0);
      for (int c = 1; c <= 66 + L; c++) begin
         tick();
         if (pulses && (c == 10 || c == 65 + L)) begin
            bus.start = 1'b1;
            bus.clear = 1'b1;
         end else begin
            bus.start = 1'b0;
            bus.clear = 1'b0;
         end
         bus.out_ready = !(c >= s && c < s + L);
         if (c < s || L == 0) cp = c;
         else if (c < s + L) cp = s;
         else cp = c - L;
         ev = (cp >= 2) && (cp <= 64) && (cp % 2 == 0);
         chk($sformatf("dump_valid_c%0d", c), 64'(bus.out_valid), 64'(ev));
         chk($sformatf("dump_done_c%0d", c), 64'(bus.done), 64'(cp == 65));
         chk($sformatf("dump_busy_c%0d", c), 64'(bus.busy), 64'(cp <= 65));
         if (ev) begin
            idx = (cp - 2) / 2;
            chk($sformatf("dump_idx_c%0d", c), 64'(bus.out_idx), 64'(idx));
            chk($sformatf("dump_data_c%0d", c), 64'(bus.out_data),
                zeros ? 64'd0 : 64'(32'hA5A5_0000 + 32'(idx)));
         end
         if (bus.out_valid && bus.out_ready) recs++;
         if (bus.done) dones++;
      end
      bus.out_ready = 1'b1;
      chk("dump_records", 64'(recs), 64'd32);
      chk("dump_done_count", 64'(dones), 64'd1);
   endtask

   task automatic run_clear();
      bit ew;
      bus.start = 1'b1;
      bus.clear = 1'b1;
      chk("clr_c0_busy", 64'(bus.busy), 64'd0);
      for (int c = 1; c <= 34; c++) begin
         tick();
         bus.start = 1'b0;
         bus.clear = 1'b0;
         ew = (c >= 1) && (c <= 32);
         chk($sformatf("clr_we_c%0d", c), 64'(bus.wr_en), 64'(ew));
         if (ew) begin
            chk($sformatf("clr_addr_c%0d", c), 64'(bus.wr_addr), 64'(c - 1));
            chk($sformatf("clr_wd_c%0d", c), 64'(bus.wr_data), 64'd0);
         end
         chk($sformatf("clr_done_c%0d", c), 64'(bus.done), 64'(c == 33));
         chk($sformatf("clr_busy_c%0d", c), 64'(bus.busy), 64'(c <= 33));
      end
   endtask

   initial begin
      n_pass = 0;
      n_tot = 0;
      rst = 1'b1;
      pl_req = 1'b0;
      pl_mode = 1'b0;
      bus.start = 1'b0;
      bus.clear = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_idx", 64'(bus.out_idx), 64'd0);
      chk("rst_data", 64'(bus.out_data), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_we", 64'(bus.wr_en), 64'd0);
      chk("rst_rdaddr", 64'(bus.rd_addr), 64'd0);
      chk("rst_wraddr", 64'(bus.wr_addr), 64'd0);
      chk("rst_wrdata", 64'(bus.wr_data), 64'd0);
      rst = 1'b0;
      tick();

      // Plain dump with ignored start pulses mid-dump and in the done cycle.
      preload(1'b0);
      run_dump(0, 0, 1'b0, 1'b1);
      // Three-cycle stall at record 5 (valid in cycle 12).
      run_dump(12, 3, 1'b0, 1'b0);
      // Clear then dump back zeros.
      preload(1'b1);
      run_clear();
      run_dump(0, 0, 1'b1, 1'b0);

      // Reset partway through a clear: writes reached regs 0..18 only.
      preload(1'b1);
      bus.start = 1'b1;
      bus.clear = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.clear = 1'b0;
      repeat (18) tick();
      chk("rclr_we_c19", 64'(bus.wr_en), 64'd1);
      chk("rclr_addr_c19", 64'(bus.wr_addr), 64'd18);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rclr_busy", 64'(bus.busy), 64'd0);
      chk("rclr_we", 64'(bus.wr_en), 64'd0);
      chk("rclr_done", 64'(bus.done), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rclr_nodone_%0d", i), 64'(bus.done), 64'd0);
      end
      for (int k = 0; k < 32; k++)
         chk($sformatf("rclr_reg%0d", k), 64'(regs[k]), (k <= 18) ? 64'd0 : 64'hFFFF_FFFF);

      // Reset while stalled on record 3, then a fresh dump restarts at index 0.
      preload(1'b0);
      bus.start = 1'b1;
      bus.clear = 1'b0;
      tick();
      bus.start = 1'b0;
      repeat (7) tick();
      bus.out_ready = 1'b0;
      tick();
      chk("rstall_valid", 64'(bus.out_valid), 64'd1);
      chk("rstall_idx", 64'(bus.out_idx), 64'd3);
      chk("rstall_data", 64'(bus.out_data), 64'hA5A5_0003);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstall_valid_after", 64'(bus.out_valid), 64'd0);
      chk("rstall_idx_after", 64'(bus.out_idx), 64'd0);
      chk("rstall_data_after", 64'(bus.out_data), 64'd0);
      chk("rstall_busy_after", 64'(bus.busy), 64'd0);
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("restart_valid", 64'(bus.out_valid), 64'd1);
      chk("restart_idx", 64'(bus.out_idx), 64'd0);
      chk("restart_data", 64'(bus.out_data), 64'hA5A5_0000);
      repeat (70) tick();
      chk("restart_idle", 64'(bus.busy), 64'd0);

      // Reset and start together: reset wins, command dropped.
      rst = 1'b1;
      bus.start = 1'b1;
      bus.clear = 1'b1;
      tick();
      rst = 1'b0;
      bus.start = 1'b0;
      bus.clear = 1'b0;
      chk("rststart_busy", 64'(bus.busy), 64'd0);
      chk("rststart_we", 64'(bus.wr_en), 64'd0);
      tick();
      chk("rststart_busy2", 64'(bus.busy), 64'd0);
      chk("rststart_we2", 64'(bus.wr_en), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
`default_nettype wire
